data_store_buffer: RTL
======================

Name: data_store_buffer

Overview:
- Posted-store buffer between the core's data-memory port (wr/rd/addr/wr_data/rd_data) and the data RAM.
- Stores are queued in a small FIFO and retire to RAM in the background.
- Loads forward from the buffer when an entry fully covers them, otherwise they read RAM after any conflict is resolved.
- Also provides a drained indication so halt only completes once every store has reached memory.

Parameters:
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- ADDR_W, 9, word address width (matches core addr).
- DEPTH, 4, buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- core_wr  in  1  store request; held stable while core_stall=1.
- core_rd  in  1  load request; held stable while core_stall=1.
- core_addr  in  ADDR_W  word address.
- core_wr_data  in  DATA_W  store data.
- core_be  in  DATA_W/8  store byte enables.
- core_rd_data  out  DATA_W  load data, valid when core_rd_valid=1.
- core_rd_valid  out  1  load completes this cycle.
- core_stall  out  1  core must hold its request.
- halt_req  in  1  core halt detected.
- drained  out  1  buffer empty and no RAM transaction in flight.
- mem_req  out  1  RAM request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_be  out  DATA_W/8  RAM byte enables.
- mem_ack  in  1  one-cycle completion pulse; read data valid in the same cycle.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset values:
  - Entries invalid, count=0, FSM=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - core_rd_valid=0, core_rd_data=0, core_stall=0, drained=1.
- Reset mid-transaction abandons the in-flight RAM access and flushes all entries.
- Storage is a circular FIFO with head/tail pointers that wrap modulo DEPTH. Each entry holds {addr, data, be}.
- Store:
  - If count<DEPTH, enqueue at the clock edge; core_stall=0 (0-cycle store).
  - If count==DEPTH, core_stall=1. This is based on the registered count and does not credit a same-cycle pop.
- Load lookup is combinational against all valid entries; the youngest match wins.
  - Youngest match with be all-ones: core_rd_data=entry data and core_rd_valid=1 in the same cycle, core_stall=0.
  - Youngest match that is partial: core_stall=1 until the buffer fully drains, then treat as a miss.
  - No match: core_stall=1 and the FSM enters LOAD.
- FSM states:
  - IDLE -> LOAD when a load miss is pending. Loads have priority over draining.
  - IDLE -> DRAIN when count>0 and no load miss is pending.
  - LOAD: mem_req=1, mem_we=0, mem_addr=core_addr. On mem_ack: core_rd_data=mem_rdata, core_rd_valid=1, core_stall=0 that cycle, next state IDLE.
  - DRAIN: mem_req=1, mem_we=1, head entry on mem_addr/mem_wdata/mem_be. On mem_ack: pop head, next state IDLE.
- RAM request signals are registered and stable from assertion until the acknowledge cycle. mem_ack while mem_req=0 is ignored.
- Enqueue and pop in the same cycle leave count unchanged; pointers advance independently.
- core_wr and core_rd both asserted: handled as a store only; the load is ignored.
- Halt:
  - halt_req=1 blocks new LOAD entry.
  - DRAIN continues until count==0.
  - drained = (count==0) && FSM==IDLE; this is combinational.
- core_rd_valid is high for exactly one cycle per load.

Optional Feature:
- Macro: DATA_STORE_BUFFER_STATS_EN.
- When defined, adds two outputs:
  - stat_fwd_cnt[15:0]: counts loads served by forwarding.
  - stat_full_cnt[15:0]: counts cycles with core_wr=1 and count==DEPTH.
- Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, the ports are absent and there is no counter logic.

Test Plan:
- Store-forward: store addr=0x010 data=0xDEADBEEF be=4'hF with mem_ack held 0 -> load addr=0x010 gives core_rd_data=0xDEADBEEF, core_rd_valid=1 same cycle, core_stall=0, no mem read issued.
- Full stall:
  - Setup: DEPTH=4, mem_ack held 0, 5 back-to-back stores to 0x001..0x005.
  - Stores 1-4 accepted; core_stall=1 on the 5th.
  - First mem_ack pops 0x001; the 5th store enqueues the following cycle.
  - RAM sees writes in order 0x001..0x005.
- Partial alias: store 0x020 be=4'b0011 data=0x0000AAAA (RAM[0x020]=0x12345678) -> load 0x020 stalls until drained, then reads RAM and returns 0x1234AAAA.
- Load priority: two stores to 0x030/0x031 queued, then load 0x040 -> next RAM request is a read of 0x040 (mem_we=0); writes follow after its ack.
- Halt drain: 3 stores queued, halt_req=1, mem_ack 2 cycles after each req -> drained stays 0 until the 3rd ack, then 1; no read issued.
- Reset mid-DRAIN: assert reset while mem_req=1 -> mem_req=0 and drained=1 immediately; after release, a load of 0x010 misses to RAM (no stale forward).

Source files
------------

// File: rtl/data_store_buffer.sv
// Posted-store buffer between the core data port and the data RAM.
// Optional stats counters: define DATA_STORE_BUFFER_STATS_EN.
module data_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_wr,
  input  logic                core_rd,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wr_data,
  input  logic [DATA_W/8-1:0] core_be,
  output logic [DATA_W-1:0]   core_rd_data,
  output logic                core_rd_valid,
  output logic                core_stall,
  input  logic                halt_req,
  output logic                drained,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DATA_STORE_BUFFER_STATS_EN
  ,
  output logic [15:0]         stat_fwd_cnt,
  output logic [15:0]         stat_full_cnt
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];

  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;

  logic full, do_wr, rd_only;
  logic hit, hit_full, fwd, miss;
  logic pop, ld_ack;
  logic [DATA_W-1:0] hit_data;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && addr_q[idx] == core_addr) begin
        hit      = 1'b1;
        hit_full = &be_q[idx];
        hit_data = data_q[idx];
      end
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign do_wr   = core_wr && !full;
  assign rd_only = core_rd && !core_wr;
  assign fwd     = rd_only && hit && hit_full;
  assign miss    = rd_only && !hit;
  assign ld_ack  = (state == LOAD) && mem_ack;
  assign pop     = (state == DRAIN) && mem_ack;

  assign mem_req = (state != IDLE);
  assign mem_we  = (state == DRAIN);
  assign drained = (count == '0) && (state == IDLE);

  assign core_rd_valid = fwd || ld_ack;
  assign core_rd_data  = fwd    ? hit_data :
                         ld_ack ? mem_rdata : '0;
  assign core_stall    = core_wr ? full :
                         (rd_only && !fwd && !ld_ack);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (miss && !halt_req)
          state_n = LOAD;
        else if (count != '0)
          state_n = DRAIN;
      end
      LOAD:    if (mem_ack) state_n = IDLE;
      DRAIN:   if (mem_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state <= state_n;
      if (do_wr) tail <= tail + PW'(1);
      if (pop)   head <= head + PW'(1);
      if (do_wr && !pop)
        count <= count + CW'(1);
      else if (pop && !do_wr)
        count <= count - CW'(1);
      if (state == IDLE && state_n == LOAD) begin
        mem_addr  <= core_addr;
        mem_wdata <= '0;
        mem_be    <= '0;
      end else if (state == IDLE && state_n == DRAIN) begin
        mem_addr  <= addr_q[head];
        mem_wdata <= data_q[head];
        mem_be    <= be_q[head];
      end
    end
  end

  // Entry payload needs no reset; count gates validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      addr_q[tail] <= core_addr;
      data_q[tail] <= core_wr_data;
      be_q[tail]   <= core_be;
    end
  end

`ifdef DATA_STORE_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fwd_cnt  <= '0;
      stat_full_cnt <= '0;
    end else begin
      if (fwd && stat_fwd_cnt != 16'hFFFF)
        stat_fwd_cnt <= stat_fwd_cnt + 16'd1;
      if (core_wr && full && stat_full_cnt != 16'hFFFF)
        stat_full_cnt <= stat_full_cnt + 16'd1;
    end
  end
`endif

endmodule
